// File: rtl/clock_ctrl_pkg.sv
// Shared types and constants for the clock-gating controller slice.
package clock_ctrl_pkg;

   typedef enum logic [1:0] {
      OFF  = 2'd0,
      WAKE = 2'd1,
      ON   = 2'd2,
      HOLD = 2'd3
   } clk_dom_state_t;

   // Conventional assignment of gated domains to controller slots
   localparam int DOM_MUL   = 0;
   localparam int DOM_CSR   = 1;
   localparam int DOM_TRACE = 2;
   localparam int DOM_SPARE = 3;

endpackage

// File: rtl/clock_gate_ctrl_dom.sv
// One gated domain: OFF/WAKE/ON/HOLD sequencer with a shared settle/idle
// down-counter. Outputs are registered so requesters never see a path
// from their own request back to rdy.
module clock_gate_ctrl_dom
   import clock_ctrl_pkg::*;
#(
   parameter int IDLE_CYCLES = 8,
   parameter int WAKE_CYCLES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic gate_en,
   input  logic req,
   output logic clk_req,
   output logic rdy,
   output logic off_nxt
);

   localparam int MAX_CYCLES = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   clk_dom_state_t state, state_nxt;
   logic [CW-1:0]  cnt, cnt_nxt;
   logic           r;

   // With gating disabled every domain behaves as if it were requested
   assign r = req | ~gate_en;

   // Next-state decode; the counter is only meaningful in WAKE and HOLD
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      unique case (state)
         OFF: begin
            if (r) begin
               state_nxt = WAKE;
               cnt_nxt   = CW'(WAKE_CYCLES - 1);
            end
         end
         WAKE: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - 1'b1;
            end else begin
               state_nxt = ON;
            end
         end
         ON: begin
            if (!r) begin
               state_nxt = HOLD;
               cnt_nxt   = CW'(IDLE_CYCLES - 1);
            end
         end
         HOLD: begin
            if (r) begin
               state_nxt = ON;
            end else if (cnt != '0) begin
               cnt_nxt = cnt - 1'b1;
            end else begin
               state_nxt = OFF;
            end
         end
         default: begin
            state_nxt = ON;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign off_nxt = (state_nxt == OFF);

   // State, counter and decoded outputs all register on the same edge
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ON;
         cnt     <= '0;
         clk_req <= 1'b1;
         rdy     <= 1'b1;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         clk_req <= (state_nxt != OFF);
         rdy     <= (state_nxt == ON) || (state_nxt == HOLD);
      end
   end

endmodule

// File: rtl/prim_clock_gate.sv
// Latch-based integrated clock gate: enable is captured while the clock is
// low so the gated output can never glitch during the high phase.
module prim_clock_gate (
   input  logic clk,
   input  logic en,
   input  logic tst_en,
   output logic gclk
);

   logic en_latch;

   // Transparent-low latch holding the enable steady across the high phase
   always_latch begin
      if (!clk) begin
         en_latch = en | tst_en;
      end
   end

   assign gclk = clk & en_latch;

endmodule

// File: rtl/clock_gate_ctrl.sv
// Clock-gating controller: one sequencer and one gate cell per domain plus
// the registered all_off sleep qualifier.
module clock_gate_ctrl
   import clock_ctrl_pkg::*;
#(
   parameter int NDOM        = 4,
   parameter int IDLE_CYCLES = 8,
   parameter int WAKE_CYCLES = 2
) (
   input  logic            g_clk,
   input  logic            g_reset,
   input  logic            tst_en,
   input  logic            cfg_gate_en,
   input  logic [NDOM-1:0] dom_req,
   output logic [NDOM-1:0] dom_rdy,
   output logic [NDOM-1:0] dom_clk,
   output logic            all_off
);

   logic [NDOM-1:0] clk_req;
   logic [NDOM-1:0] off_nxt;

   for (genvar i = 0; i < NDOM; i++) begin : g_dom
      clock_gate_ctrl_dom #(
         .IDLE_CYCLES (IDLE_CYCLES),
         .WAKE_CYCLES (WAKE_CYCLES)
      ) u_dom (
         .clk     (g_clk),
         .reset   (g_reset),
         .gate_en (cfg_gate_en),
         .req     (dom_req[i]),
         .clk_req (clk_req[i]),
         .rdy     (dom_rdy[i]),
         .off_nxt (off_nxt[i])
      );

      // Reset forces the gate open so synchronous resets reach gated flops
      // even before the sequencer flops have been initialised
      prim_clock_gate u_gate (
         .clk    (g_clk),
         .en     (clk_req[i] | g_reset),
         .tst_en (tst_en),
         .gclk   (dom_clk[i])
      );
   end

   // Sleep qualifier taken from next-state so it lines up with the states
   always_ff @(posedge g_clk) begin
      if (g_reset) begin
         all_off <= 1'b0;
      end else begin
         all_off <= &off_nxt;
      end
   end

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Self-checking bench for clock_gate_ctrl: directed literal checks followed
// by randomized traffic compared against a run-length behavioural model.
module tb_clock_gate_ctrl;

   localparam int NDOM        = 4;
   localparam int IDLE_CYCLES = 8;
   localparam int WAKE_CYCLES = 2;

   logic            g_clk = 1'b0;
   logic            g_reset;
   logic            tst_en;
   logic            cfg_gate_en;
   logic [NDOM-1:0] dom_req;
   logic [NDOM-1:0] dom_rdy;
   logic [NDOM-1:0] dom_clk;
   logic            all_off;

   int checks   = 0;
   int failures = 0;

   clock_gate_ctrl #(
      .NDOM        (NDOM),
      .IDLE_CYCLES (IDLE_CYCLES),
      .WAKE_CYCLES (WAKE_CYCLES)
   ) dut (
      .g_clk       (g_clk),
      .g_reset     (g_reset),
      .tst_en      (tst_en),
      .cfg_gate_en (cfg_gate_en),
      .dom_req     (dom_req),
      .dom_rdy     (dom_rdy),
      .dom_clk     (dom_clk),
      .all_off     (all_off)
   );

   // Free-running core clock, period 10
   always #5 g_clk = ~g_clk;

   // Model: a domain is either stopped, waking (edges left until ready),
   // or ready; a ready domain counts consecutive unrequested edges and
   // stops once that run exceeds the idle allowance
   bit running  [NDOM];
   bit ready    [NDOM];
   int wake_rem [NDOM];
   int idle_run [NDOM];
   bit started = 1'b0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic gate, input logic tst, input logic [NDOM-1:0] req);
      g_reset     = rst;
      cfg_gate_en = gate;
      tst_en      = tst;
      dom_req     = req;
   endtask

   initial begin
      for (int i = 0; i < NDOM; i++) begin
         running[i]  = 1'b1;
         ready[i]    = 1'b1;
         wake_rem[i] = 0;
         idle_run[i] = 0;
      end
   end

   // Advance the model on each edge and check the gated clocks mid-high-phase
   always @(posedge g_clk) begin
      logic [NDOM-1:0] gate_exp;
      bit r;
      for (int i = 0; i < NDOM; i++) begin
         gate_exp[i] = running[i] | g_reset | tst_en;
      end
      for (int i = 0; i < NDOM; i++) begin
         r = dom_req[i] | ~cfg_gate_en;
         if (g_reset) begin
            running[i]  = 1'b1;
            ready[i]    = 1'b1;
            wake_rem[i] = 0;
            idle_run[i] = 0;
         end else if (!running[i]) begin
            if (r) begin
               running[i]  = 1'b1;
               wake_rem[i] = WAKE_CYCLES;
            end
         end else if (!ready[i]) begin
            wake_rem[i]--;
            if (wake_rem[i] == 0) begin
               ready[i]    = 1'b1;
               idle_run[i] = 0;
            end
         end else begin
            idle_run[i] = r ? 0 : idle_run[i] + 1;
            if (idle_run[i] > IDLE_CYCLES) begin
               running[i]  = 1'b0;
               ready[i]    = 1'b0;
               idle_run[i] = 0;
            end
         end
      end
      #1;
      if (started) begin
         checkOutput("model_dom_clk", 32'(dom_clk), 32'(gate_exp));
      end
      started = 1'b1;
   end

   // Compare registered outputs against the model in the low phase
   always @(negedge g_clk) begin
      logic [NDOM-1:0] rdy_exp;
      bit off_exp;
      if (started) begin
         off_exp = 1'b1;
         for (int i = 0; i < NDOM; i++) begin
            rdy_exp[i] = ready[i];
            if (running[i]) off_exp = 1'b0;
         end
         checkOutput("model_dom_rdy", 32'(dom_rdy), 32'(rdy_exp));
         checkOutput("model_all_off", 32'(all_off), 32'(off_exp));
      end
   end

   // Directed scenarios with hand-computed expectations, then random traffic
   initial begin
      applyStimulus(1'b1, 1'b1, 1'b0, '0);
      repeat (3) @(negedge g_clk);
      checkOutput("reset_rdy", 32'(dom_rdy), 32'hF);
      checkOutput("reset_all_off", 32'(all_off), 32'h0);

      g_reset = 1'b0;
      for (int i = 1; i <= IDLE_CYCLES + 1; i++) begin
         @(negedge g_clk);
         checkOutput("idle_after_reset_rdy", 32'(dom_rdy), (i <= IDLE_CYCLES) ? 32'hF : 32'h0);
      end
      checkOutput("idle_after_reset_all_off", 32'(all_off), 32'h1);

      dom_req = 4'b0001;
      @(negedge g_clk);
      checkOutput("wake_edge_w_rdy", 32'(dom_rdy), 32'h0);
      checkOutput("wake_all_off", 32'(all_off), 32'h0);
      @(negedge g_clk);
      checkOutput("wake_edge_w1_rdy", 32'(dom_rdy), 32'h0);
      @(negedge g_clk);
      checkOutput("wake_edge_w2_rdy", 32'(dom_rdy), 32'h1);

      dom_req = 4'b0000;
      for (int i = 1; i <= IDLE_CYCLES + 1; i++) begin
         @(negedge g_clk);
         checkOutput("hold_rdy", 32'(dom_rdy), (i <= IDLE_CYCLES) ? 32'h1 : 32'h0);
      end
      checkOutput("hold_all_off", 32'(all_off), 32'h1);

      cfg_gate_en = 1'b0;
      for (int i = 1; i <= 1 + WAKE_CYCLES; i++) begin
         @(negedge g_clk);
         checkOutput("force_on_rdy", 32'(dom_rdy), (i <= WAKE_CYCLES) ? 32'h0 : 32'hF);
      end
      repeat (5) @(negedge g_clk);
      checkOutput("force_on_held_rdy", 32'(dom_rdy), 32'hF);

      cfg_gate_en = 1'b1;
      for (int i = 1; i <= IDLE_CYCLES + 1; i++) begin
         @(negedge g_clk);
         checkOutput("regate_all_off", 32'(all_off), (i <= IDLE_CYCLES) ? 32'h0 : 32'h1);
      end

      tst_en = 1'b1;
      @(posedge g_clk);
      #2;
      checkOutput("tst_dom_clk", 32'(dom_clk), 32'hF);
      @(negedge g_clk);
      checkOutput("tst_rdy", 32'(dom_rdy), 32'h0);
      checkOutput("tst_all_off", 32'(all_off), 32'h1);
      tst_en = 1'b0;

      for (int c = 0; c < 3000; c++) begin
         @(negedge g_clk);
         for (int i = 0; i < NDOM; i++) begin
            if ($urandom_range(7) == 0) dom_req[i] = ~dom_req[i];
         end
         if ($urandom_range(63) == 0) cfg_gate_en = ~cfg_gate_en;
         if ($urandom_range(31) == 0) tst_en = ~tst_en;
         g_reset = ($urandom_range(199) == 0);
      end
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
      repeat (2) @(negedge g_clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/clock_gate_ctrl.md
# clock_gate_ctrl

Clock-gating controller for the core's gated sub-domains (e.g. multiplier, CSR file, trace unit). It owns one `prim_clock_gate` per domain and sequences each domain's clock request with a wake-up settle window and an idle hold-off, so requesters see a registered, glitch-free `dom_rdy` handshake. It sits at top level between the free-running `g_clk` and the gated domain clocks, configured by a CSR-driven gating enable.

## Interface
Parameters:
- `NDOM`, 4, number of gated domains (1..16).
- `IDLE_CYCLES`, 8, cycles a clock is held on after its request drops (>=1).
- `WAKE_CYCLES`, 2, cycles between clock restart and `dom_rdy` (>=1).

Ports:
- `g_clk`  in  1  free-running core clock.
- `g_reset`  in  1  reset; synchronous, active-high.
- `tst_en`  in  1  scan/test enable, passed to every gate cell's `tst_en`.
- `cfg_gate_en`  in  1  1: gating permitted; 0: every domain is forced on.
- `dom_req`  in  NDOM  per-domain clock request (level).
- `dom_rdy`  out  NDOM  domain clock running and stable (registered).
- `dom_clk`  out  NDOM  gated domain clocks.
- `all_off`  out  1  every domain is in OFF (registered); sleep qualifier.

## Operation
- Per-domain FSM, states OFF, WAKE, ON, HOLD, plus a down-counter of width `$clog2(max(IDLE_CYCLES,WAKE_CYCLES)+1)`.
- `clk_req = (state != OFF)`. `dom_rdy = (state == ON || state == HOLD)`. Both are decoded from flops only, with no combinational path from `dom_req`.
- Reset: every domain goes to ON with the counter at 0. The clocks must run during reset so that synchronous resets reach the gated flops. Reset values: `dom_rdy` all 1, `all_off` 0, every `dom_clk` follows `g_clk`.
- Effective request is `r = dom_req[i] | !cfg_gate_en`.
- OFF:
  - r=1: go to WAKE and load the counter with `WAKE_CYCLES-1`.
  - r=0: stay in OFF.
- WAKE:
  - Counter nonzero: decrement.
  - Counter == 0: go to ON.
  - The wake is never aborted. If r drops during WAKE, the domain still completes to ON, then moves to HOLD.
- ON:
  - r=0: go to HOLD and load the counter with `IDLE_CYCLES-1`.
  - r=1: stay in ON.
- HOLD:
  - r=1: go to ON, leaving the counter value irrelevant.
  - r=0 and counter nonzero: decrement.
  - r=0 and counter == 0: go to OFF.
- `cfg_gate_en`=0: OFF and HOLD domains move to WAKE and ON respectively on the next edge. Domains in WAKE finish their settle window, because the clock must still stabilize.
- `all_off` is the registered AND over `state==OFF`, computed from next-state so that it is coincident with the states.
- `tst_en` does not affect the FSMs; it only forces the gate cells open.
- Domains are fully independent. No arbitration or staggering is performed.

## Timing
- Wake latency: `dom_req` first sampled 1 at edge w while in OFF. Then `clk_req` is 1 after edge w, and `dom_rdy` is 1 after edge w+`WAKE_CYCLES`.
- The gate cell's negative-level latch passes `clk_req` in the low phase. The first gated rising edge is therefore edge w+1.
- Idle hold-off: `dom_req` first sampled 0 at edge e0 while in ON.
  - HOLD is entered after e0.
  - If `dom_req` stays 0, OFF is entered after edge e0+`IDLE_CYCLES`.
  - `dom_rdy` and `clk_req` fall together after that edge.
- Re-request in HOLD at edge h: ON after h. `dom_rdy` never drops.
- Request in the same cycle that HOLD would expire (counter==0, r=1): go to ON, not OFF.
- Reset asserted mid-WAKE or mid-HOLD: ON after the next edge, counters cleared.

## Structure
- Package `clock_ctrl_pkg` holds:
  - `clk_dom_state_t` enum (OFF=2'd0, WAKE=2'd1, ON=2'd2, HOLD=2'd3).
  - Domain index constants.
- Sub-module `clock_gate_ctrl_dom` holds one FSM plus its counter, with outputs `clk_req` and `rdy`.
- The top generates `NDOM` instances of `clock_gate_ctrl_dom`, `NDOM` instances of `prim_clock_gate`, and the `all_off` register.

## Test plan
- Reset with `dom_req`=0, `IDLE_CYCLES`=8: `dom_rdy`=all 1 during reset and for 8 cycles after release, then 0. `all_off`=1 on the same cycle.
- Domain 0 in OFF, `dom_req[0]` raised at edge w: `dom_clk[0]` pulses from edge w+1, `dom_rdy[0]`=1 after edge w+2, other domains stay OFF.
- Domain 1 in ON, request dropped for 5 cycles, then re-raised: `dom_rdy[1]` stays 1 throughout and `dom_clk[1]` never stops.
- Re-request exactly on the HOLD-expiry edge: domain returns to ON and no clock gap is observed.
- `cfg_gate_en`=0 with all domains OFF: all `dom_rdy`=1 after 1+`WAKE_CYCLES` edges, held indefinitely. Restoring `cfg_gate_en`=1 gives `all_off`=1 `IDLE_CYCLES`+1 edges later.
- `tst_en`=1 with all domains OFF: `dom_clk` toggles, while `dom_rdy`=0 and `all_off`=1 are unchanged.
